// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer.
package fir_pkg;

    localparam int unsigned SampleW  = 8;
    localparam int unsigned DefNtaps = 4;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StHold
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep shift register of samples with an indexed read port.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = DefNtaps
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en_i,
    input  logic [SampleW-1:0]          din_i,
    input  logic [idx_w(NTAPS)-1:0]     rd_idx_i,
    output logic [SampleW-1:0]          dout_o
);

    logic [SampleW-1:0] tap_q [NTAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            tap_q[0] <= din_i;
            for (int i = 1; i < NTAPS; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign dout_o = tap_q[rd_idx_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequential FIR: one multiply-accumulate per cycle through an external multiplier.
// Define FIR_SAT_EN to saturate the result to 8'hFF instead of wrapping.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = DefNtaps,
    parameter int unsigned ACC_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_sample,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [7:0]  mul_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int unsigned IdxW = idx_w(NTAPS);

    state_e             state_q, state_d;
    logic [IdxW-1:0]    k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [7:0]         out_q, out_d;
    logic [7:0]         coef_q [NTAPS];
    logic [7:0]         tap_rd;
    logic               accept;
    logic               coef_wr_en;

    assign accept     = (state_q == StIdle) && in_valid;
    assign coef_wr_en = (state_q == StIdle) && coef_we && (32'(coef_addr) < NTAPS);
    assign acc_sum    = acc_q + ACC_W'(mul_c);
    assign out_data   = out_q;

    fir_delay_line #(
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (accept),
        .din_i      (in_sample),
        .rd_idx_i   (k_q),
        .dout_o     (tap_rd)
    );

    // Written on the same edge a sample is accepted, so that sample's MAC sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr_en) begin
            coef_q[coef_addr[IdxW-1:0]] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        out_d     = out_q;
        mul_a     = '0;
        mul_b     = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                mul_a = tap_rd;
                mul_b = coef_q[k_q];
                acc_d = acc_sum;
                k_d   = k_q + IdxW'(1);
                if (k_q == IdxW'(NTAPS - 1)) begin
                    k_d     = '0;
                    state_d = StHold;
`ifdef FIR_SAT_EN
                    out_d = (acc_sum > ACC_W'(255)) ? 8'hFF : acc_sum[7:0];
`else
                    out_d = acc_sum[7:0];
`endif
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench for fir_tap_sequencer against an array-based filter model.
module tb_fir_tap_sequencer;

    localparam int NT    = 4;
    localparam int ACC_W = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sample = '0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic [7:0] mul_a, mul_b, mul_c;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [15:0] prod;

    int n_cmp = 0;
    int n_err = 0;
    int m_tap  [NT];
    int m_coef [NT];
    int got;

    always #5 clk = ~clk;

    // External multiplier: low byte of the product, combinational.
    assign prod  = {8'd0, mul_a} * {8'd0, mul_b};
    assign mul_c = prod[7:0];

    fir_tap_sequencer #(
        .NTAPS (NT),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out();
        int acc = 0;
        for (int k = 0; k < NT; k++) begin
            acc = (acc + ((m_tap[k] * m_coef[k]) % 256)) % (1 << ACC_W);
        end
`ifdef FIR_SAT_EN
        return (acc > 255) ? 255 : acc;
`else
        return acc % 256;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_tap[k]  = 0;
            m_coef[k] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic coef_write(input int addr, input int data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = 8'(data);
        @(posedge clk);
        #1 coef_we = 1'b0;
        if (addr < NT) m_coef[addr] = data;
    endtask

    // wmode: 0 none, 1 coefficient write with the acceptance, 2 write during 2nd MAC cycle.
    task automatic run_sample(input int s, input int hold, input int wmode,
                              input int waddr, input int wdata, output int res);
        int exp;
        @(negedge clk);
        check("in_ready_idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = 8'(s);
        out_ready = 1'b0;
        if (wmode == 1) begin
            coef_we   = 1'b1;
            coef_addr = 4'(waddr);
            coef_data = 8'(wdata);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (wmode == 1 && waddr < NT) m_coef[waddr] = wdata;
        for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
        m_tap[0] = s;
        exp = model_out();
        for (int cyc = 1; cyc <= NT; cyc++) begin
            @(negedge clk);
            coef_we = 1'b0;
            check("mac_out_valid", int'(out_valid), 0);
            check("mac_in_ready", int'(in_ready), 0);
            check("mac_mul_a", int'(mul_a), m_tap[cyc-1]);
            check("mac_mul_b", int'(mul_b), m_coef[cyc-1]);
            if (wmode == 2 && cyc == 2) begin
                coef_we   = 1'b1;
                coef_addr = 4'(waddr);
                coef_data = 8'(wdata);
            end
        end
        @(negedge clk);
        coef_we = 1'b0;
        check("valid_at_n_plus_1", int'(out_valid), 1);
        check("out_data", int'(out_data), exp);
        res = int'(out_data);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), exp);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_mul_a", int'(mul_a), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("back_to_idle", int'(in_ready), 1);
        check("valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_mul_a", int'(mul_a), 0);
        check("rst_mul_b", int'(mul_b), 0);
        @(negedge clk);
        rst = 1'b0;

        // Unity coefficients: running sums.
        for (int i = 0; i < NT; i++) coef_write(i, 1);
        run_sample(1, 0, 0, 0, 0, got); check("unity_1", got, 1);
        run_sample(2, 0, 0, 0, 0, got); check("unity_2", got, 3);
        run_sample(3, 0, 0, 0, 0, got); check("unity_3", got, 6);
        run_sample(4, 0, 0, 0, 0, got); check("unity_4", got, 10);

        // Overflow past 255.
        do_reset();
        for (int i = 0; i < NT; i++) coef_write(i, 1);
        run_sample(100, 0, 0, 0, 0, got); check("ovf_1", got, 100);
        run_sample(100, 0, 0, 0, 0, got); check("ovf_2", got, 200);
        run_sample(100, 0, 0, 0, 0, got);
`ifdef FIR_SAT_EN
        check("ovf_3_sat", got, 255);
`else
        check("ovf_3_wrap", got, 44);
`endif

        // Back-pressure for 6 cycles in HOLD.
        run_sample(7, 6, 0, 0, 0, got);

        // Writes during MAC and out-of-range writes are dropped.
        do_reset();
        coef_write(0, 1);
        run_sample(9, 0, 2, 0, 5, got); check("mac_wr_first", got, 9);
        run_sample(2, 0, 0, 0, 0, got); check("mac_wr_ignored", got, 2);
        coef_write(9, 7);
        run_sample(2, 0, 0, 0, 0, got); check("addr9_ignored", got, 2);
        // Same-cycle write and acceptance: taps {4,2,2,9}, coef0 becomes 3.
        run_sample(4, 0, 1, 0, 3, got); check("same_cycle_wr", got, 12);

        // Reset in the 2nd MAC cycle.
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 8'd50;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("midmac_rst_in_ready", int'(in_ready), 1);
        check("midmac_rst_valid", int'(out_valid), 0);
        check("midmac_rst_data", int'(out_data), 0);
        check("midmac_rst_mul_a", int'(mul_a), 0);
        check("midmac_rst_mul_b", int'(mul_b), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("no_valid_after_rst", int'(out_valid), 0);
        end
        // Coefficients are zero after reset.
        run_sample(77, 0, 0, 0, 0, got); check("coef_cleared", got, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1)
                coef_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 4, meaning number of filter taps (2..16).
REQ-002 SHALL have parameter ACC_W, default 10, meaning accumulator width, at least 8+clog2(NTAPS).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  meaning a new sample is offered.
REQ-006 SHALL have port in_ready  out  1  meaning the block accepts a sample this cycle.
REQ-007 SHALL have port in_sample  in  8  meaning unsigned 8-bit input sample.
REQ-008 SHALL have port coef_we  in  1  meaning coefficient write strobe.
REQ-009 SHALL have port coef_addr  in  4  meaning coefficient tap index.
REQ-010 SHALL have port coef_data  in  8  meaning unsigned 8-bit coefficient.
REQ-011 SHALL have port mul_a  out  8  meaning sample operand driven to the external 8-bit multiplier.
REQ-012 SHALL have port mul_b  out  8  meaning coefficient operand driven to the external multiplier.
REQ-013 SHALL have port mul_c  in  8  meaning combinational product from the multiplier (low 8 bits of mul_a*mul_b, same cycle).
REQ-014 SHALL have port out_valid  out  1  meaning filter result available.
REQ-015 SHALL have port out_ready  in  1  meaning downstream accepts the result.
REQ-016 SHALL have port out_data  out  8  meaning filter result.

Function
REQ-017 SHALL implement states IDLE, MAC and HOLD; in_ready=1 only in IDLE, out_valid=1 only in HOLD.
REQ-018 In IDLE with in_valid=1, SHALL shift the delay line (tap[k]<=tap[k-1], tap[0]<=in_sample), clear acc, set k=0 and go to MAC.
REQ-019 In MAC, SHALL drive mul_a=tap[k] and mul_b=coef[k], add mul_c zero-extended to acc, and increment k; after k=NTAPS-1, SHALL go to HOLD.
REQ-020 Outside MAC, mul_a and mul_b SHALL be 0.
REQ-021 out_valid SHALL rise exactly NTAPS+1 cycles after the acceptance edge; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 In HOLD with out_ready=1, SHALL return to IDLE; maximum throughput is one sample per NTAPS+2 cycles.
REQ-023 acc SHALL be ACC_W bits unsigned, and additions SHALL wrap modulo 2^ACC_W.
REQ-024 coef_we SHALL write coef[coef_addr] only in IDLE; writes in MAC/HOLD or with coef_addr>=NTAPS SHALL be ignored.
REQ-025 A coefficient write and a sample acceptance in the same IDLE cycle SHALL both take effect, and the new coefficient SHALL be used by that sample's MAC.

Reset
REQ-026 rst SHALL force the following regardless of clock: state=IDLE, k=0, acc=0, all taps=0, all coefficients=0, out_valid=0, out_data=0, in_ready=1.
REQ-027 Reset asserted mid-MAC or mid-HOLD SHALL discard the partial result; no out_valid pulse follows release.

Configuration
REQ-028 Macro FIR_SAT_EN defined: out_data SHALL be 8'hFF when acc>255, otherwise acc[7:0].
REQ-029 Macro FIR_SAT_EN undefined: out_data SHALL be acc[7:0] (wrap).

Structure
REQ-030 Package fir_pkg SHALL hold the state enum typedef, the sample/coefficient width constant (8) and the default NTAPS.
REQ-031 The delay line SHALL be sub-module fir_delay_line (NTAPS x 8-bit shift register with shift enable and indexed read port).
REQ-032 The multiplier SHALL NOT be instantiated inside; it is connected at the level above via mul_a/mul_b/mul_c.

Verification (NTAPS=4, bench models mul_c=(mul_a*mul_b)%256)
REQ-033 All coef=1; samples 1,2,3,4 with out_ready=1 -> out_data 1,3,6,10, each out_valid 5 cycles after acceptance.
REQ-034 All coef=1; samples 100,100,100 -> third result 255 with FIR_SAT_EN and 44 without.
REQ-035 Hold out_ready=0 for 6 cycles in HOLD -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 Write coef[0]=5 during MAC -> ignored; the next sample 2 with other coefficients 0 -> out_data 2 (old coef[0]=1).
REQ-037 Assert rst at the 2nd MAC cycle -> all outputs reset immediately; no out_valid until a new sample is accepted.
REQ-038 coef_addr=9 write -> no coefficient changes; results are unchanged from the prior run.
